imem_uart_loader: RTL

- Boot-time instruction-memory loader between the UART receiver and the four 512x8 imem SRAM byte lanes.
- Parses a framed byte stream and writes 32-bit little-endian words into the lanes, holding the core in reset throughout.
- On completion it hands the SRAM ports to the core's fetch interface.
- Replaces the bench-side imem preload and write/read port mux with synthesizable hardware.

---
 rtl/imem_uart_loader_if.sv | 26 ++
 rtl/imem_uart_loader.sv | 135 +++++++++++++
 2 files changed

// File: rtl/imem_uart_loader_if.sv
// imem_uart_loader_if: UART byte stream, core imem request and SRAM lane bus of the imem loader
interface imem_uart_loader_if #(parameter int ADDR_W = 9);
   logic [7:0]          rx_data;
   logic                rx_valid;
   logic                core_rst_n;
   logic                load_done;
   logic                load_err;
   logic [3:0]          core_CEN;
   logic [3:0]          core_GWEN;
   logic [31:0]         core_WEN;
   logic [4*ADDR_W-1:0] core_A;
   logic [31:0]         core_D;
   logic [3:0]          CEN;
   logic [3:0]          GWEN;
   logic [31:0]         WEN;
   logic [4*ADDR_W-1:0] A;
   logic [31:0]         D;
   modport master (
      output rx_data, rx_valid, core_CEN, core_GWEN, core_WEN, core_A, core_D,
      input  core_rst_n, load_done, load_err, CEN, GWEN, WEN, A, D
   );
   modport slave (
      input  rx_data, rx_valid, core_CEN, core_GWEN, core_WEN, core_A, core_D,
      output core_rst_n, load_done, load_err, CEN, GWEN, WEN, A, D
   );
endinterface

// File: rtl/imem_uart_loader.sv
// imem_uart_loader: boot loader writing a UART frame into four imem byte lanes, then handing the lanes to the core.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
module imem_uart_loader #(
   parameter int         DEPTH     = 512,
   parameter int         ADDR_W    = 9,
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter int         TIMEOUT   = 1_000_000
) (
   input logic              clk,
   input logic              rst_n,
   imem_uart_loader_if.slave bus
);
   localparam int CW = $clog2(TIMEOUT + 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CKSUM, DONE, ERROR} state_t;
   localparam state_t ZERO_ST = CKSUM;
   localparam state_t WORD_ST = CKSUM;
`else
   typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, LAST, DONE, ERROR} state_t;
   localparam state_t ZERO_ST = DONE;
   localparam state_t WORD_ST = LAST;
`endif
   state_t            state;
   logic [15:0]       len, word_idx, n;
   logic [1:0]        byte_cnt;
   logic [31:0]       stage, stage_nx;
   logic [CW-1:0]     idle_cnt;
   logic              timeout, in_frame, done;
   logic [3:0]        cen_r, gwen_r;
   logic [31:0]       wen_r, d_r;
   logic [ADDR_W-1:0] a_r;
   logic              core_rst_n_r, load_done_r, load_err_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        cksum;
   assign in_frame = state inside {LEN_LO, LEN_HI, DATA, CKSUM};
`else
   assign in_frame = state inside {LEN_LO, LEN_HI, DATA};
`endif
   assign n       = {bus.rx_data, len[7:0]};
   assign timeout = idle_cnt == CW'(TIMEOUT);
   assign done    = state == DONE;
   // Staging word with the incoming byte dropped into its lane
   always_comb begin
      stage_nx = stage;
      stage_nx[8*byte_cnt +: 8] = bus.rx_data;
   end
   // Frame parser with registered SRAM write strobes and status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         len          <= '0;
         word_idx     <= '0;
         byte_cnt     <= '0;
         stage        <= '0;
         idle_cnt     <= '0;
         cen_r        <= '1;
         gwen_r       <= '1;
         wen_r        <= '1;
         a_r          <= '0;
         d_r          <= '0;
         core_rst_n_r <= 1'b0;
         load_done_r  <= 1'b0;
         load_err_r   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         cksum        <= '0;
`endif
      end else begin
         cen_r        <= '1;
         gwen_r       <= '1;
         wen_r        <= '1;
         core_rst_n_r <= load_done_r;
         idle_cnt     <= bus.rx_valid ? '0 : idle_cnt + CW'(!timeout);
         if (in_frame && timeout) begin
            state      <= ERROR;
            load_err_r <= 1'b1;
            byte_cnt   <= '0;
         end else begin
            case (state)
               IDLE, ERROR: if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
                  state      <= LEN_LO;
                  load_err_r <= 1'b0;
                  word_idx   <= '0;
                  byte_cnt   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  cksum      <= '0;
`endif
               end
               LEN_LO: if (bus.rx_valid) begin
                  len[7:0] <= bus.rx_data;
                  state    <= LEN_HI;
               end
               LEN_HI: if (bus.rx_valid) begin
                  len[15:8]  <= bus.rx_data;
                  state      <= n == '0 ? ZERO_ST : n > 16'(DEPTH) ? ERROR : DATA;
                  load_err_r <= n > 16'(DEPTH);
               end
               DATA: if (bus.rx_valid) begin
                  stage    <= stage_nx;
                  byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  cksum    <= cksum ^ bus.rx_data;
`endif
                  if (byte_cnt == 2'd3) begin
                     cen_r    <= '0;
                     gwen_r   <= '0;
                     wen_r    <= '0;
                     a_r      <= word_idx[ADDR_W-1:0];
                     d_r      <= stage_nx;
                     word_idx <= word_idx + 16'd1;
                     if (word_idx == len - 16'd1) state <= WORD_ST;
                  end
               end
`ifdef IMEM_LOADER_CHECKSUM_EN
               CKSUM: if (bus.rx_valid) begin
                  state      <= bus.rx_data == cksum ? DONE : ERROR;
                  load_err_r <= bus.rx_data != cksum;
               end
`else
               LAST: state <= DONE;
`endif
               DONE: load_done_r <= 1'b1;
               default: state <= IDLE;
            endcase
         end
      end
   end
   assign bus.CEN        = done ? bus.core_CEN  : cen_r;
   assign bus.GWEN       = done ? bus.core_GWEN : gwen_r;
   assign bus.WEN        = done ? bus.core_WEN  : wen_r;
   assign bus.A          = done ? bus.core_A    : {4{a_r}};
   assign bus.D          = done ? bus.core_D    : d_r;
   assign bus.core_rst_n = core_rst_n_r;
   assign bus.load_done  = load_done_r;
   assign bus.load_err   = load_err_r;
endmodule
